// File: rtl/eth_pkg.sv
// Shared constants and FSM state encoding for the GMII transmit path.
`default_nettype none

package eth_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY_REF  = 32'hEDB8_8320;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_SFD  = 3'd2,
        S_DATA = 3'd3,
        S_PAD  = 3'd4,
        S_FCS  = 3'd5,
        S_GAP  = 3'd6
    } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/eth_crc32_d8.sv
// Combinational CRC-32 (reflected) next-state for one byte per clock.
`default_nettype none

module eth_crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    always_comb begin
        c = crc_in ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY_REF) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

`default_nettype wire

// File: rtl/eth_gmii_tx.sv
// GMII frame transmitter: preamble, SFD, buffered frame, optional pad, FCS, IFG.
`default_nettype none

module eth_gmii_tx #(
    parameter int DEPTH   = 2048,
    parameter int MAX_LEN = 1514,
    parameter int MIN_LEN = 60,
    parameter int PAD_EN  = 1,
    parameter int IFG     = 12
) (
    input  logic        phy1_125M_clk,
    input  logic        reset_n,
    input  logic        wr_en,
    input  logic [10:0] wr_addr,
    input  logic [7:0]  wr_data,
    input  logic        start,
    input  logic [10:0] len,
    output logic        busy,
    output logic        done,
    output logic        tx_en,
    output logic [7:0]  tx_data
);

    import eth_pkg::*;

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [10:0] MAX_N   = 11'(MAX_LEN);
    localparam logic [10:0] MIN_N   = 11'(MIN_LEN);
    localparam logic [10:0] IFG_N   = 11'(IFG);
    localparam logic [10:0] PRE_CNT = 11'd7;

    tx_state_t   state, state_nxt;
    logic [10:0] cnt, cnt_nxt;
    logic [10:0] frame_len, frame_len_nxt;
    logic [AW-1:0] rd_addr, rd_addr_nxt;
    logic [7:0]  rd_data;
    logic [31:0] crc, crc_nxt, crc_step;
    logic        busy_nxt, done_nxt, tx_en_nxt;
    logic [7:0]  tx_data_nxt;
    logic        pad_needed;

    logic [7:0] mem [0:DEPTH-1];

    // Buffer is host-owned only while idle; the read port runs every cycle.
    always_ff @(posedge phy1_125M_clk) begin
        if (wr_en && !busy && (32'(wr_addr) < DEPTH)) begin
            mem[AW'(wr_addr)] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

    eth_crc32_d8 u_crc (
        .crc_in  (crc),
        .data    ((state == S_DATA) ? rd_data : 8'h00),
        .crc_out (crc_step)
    );

    assign pad_needed = (PAD_EN != 0) && (frame_len < MIN_N);

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        frame_len_nxt = frame_len;
        rd_addr_nxt   = rd_addr;
        crc_nxt       = crc;
        busy_nxt      = busy;
        done_nxt      = 1'b0;
        tx_en_nxt     = 1'b0;
        tx_data_nxt   = 8'h00;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt     = S_PRE;
                    cnt_nxt       = '0;
                    frame_len_nxt = (len > MAX_N) ? MAX_N : len;
                    rd_addr_nxt   = '0;
                    crc_nxt       = CRC_INIT;
                    busy_nxt      = 1'b1;
                end
            end
            S_PRE: begin
                tx_en_nxt   = 1'b1;
                tx_data_nxt = PREAMBLE_BYTE;
                cnt_nxt     = cnt + 11'd1;
                if (cnt + 11'd1 == PRE_CNT) begin
                    state_nxt = S_SFD;
                end
            end
            S_SFD: begin
                tx_en_nxt   = 1'b1;
                tx_data_nxt = SFD_BYTE;
                rd_addr_nxt = rd_addr + 1'b1;
                cnt_nxt     = '0;
                if (frame_len != 11'd0) begin
                    state_nxt = S_DATA;
                end else if (pad_needed) begin
                    state_nxt = S_PAD;
                end else begin
                    state_nxt = S_FCS;
                end
            end
            S_DATA: begin
                tx_en_nxt   = 1'b1;
                tx_data_nxt = rd_data;
                crc_nxt     = crc_step;
                rd_addr_nxt = rd_addr + 1'b1;
                cnt_nxt     = cnt + 11'd1;
                if (cnt + 11'd1 == frame_len) begin
                    if (pad_needed) begin
                        state_nxt = S_PAD;
                    end else begin
                        state_nxt = S_FCS;
                        cnt_nxt   = '0;
                    end
                end
            end
            S_PAD: begin
                // cnt carries on from DATA so it counts total bytes sent.
                tx_en_nxt   = 1'b1;
                crc_nxt     = crc_step;
                cnt_nxt     = cnt + 11'd1;
                if (cnt + 11'd1 == MIN_N) begin
                    state_nxt = S_FCS;
                    cnt_nxt   = '0;
                end
            end
            S_FCS: begin
                tx_en_nxt   = 1'b1;
                tx_data_nxt = 8'((~crc) >> {cnt[1:0], 3'b000});
                cnt_nxt     = cnt + 11'd1;
                if (cnt[1:0] == 2'd3) begin
                    state_nxt = S_GAP;
                    cnt_nxt   = '0;
                end
            end
            S_GAP: begin
                cnt_nxt = cnt + 11'd1;
                if (cnt + 11'd1 == IFG_N) begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge phy1_125M_clk) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            frame_len <= '0;
            rd_addr   <= '0;
            crc       <= CRC_INIT;
            busy      <= 1'b0;
            done      <= 1'b0;
            tx_en     <= 1'b0;
            tx_data   <= 8'h00;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            frame_len <= frame_len_nxt;
            rd_addr   <= rd_addr_nxt;
            crc       <= crc_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            tx_en     <= tx_en_nxt;
            tx_data   <= tx_data_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_eth_gmii_tx.sv
// Directed bench for eth_gmii_tx: one unpadded and one padded instance share the inputs.
`default_nettype none

module tb_eth_gmii_tx;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [10:0] wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic        start = 1'b0;
    logic [10:0] len = '0;
    logic        busy0, done0, en0, busy1, done1, en1;
    logic [7:0]  d0, d1;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] mem_model [0:2047];
    logic [7:0] exp_q [$];
    logic [7:0] cap [$];
    int first_en, last_en, done_cyc, nz, busy_at1;

    always #4 clk = ~clk;

    eth_gmii_tx #(.PAD_EN(0)) dut0 (
        .phy1_125M_clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .len(len), .busy(busy0), .done(done0),
        .tx_en(en0), .tx_data(d0)
    );

    eth_gmii_tx #(.PAD_EN(1)) dut1 (
        .phy1_125M_clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .len(len), .busy(busy1), .done(done1),
        .tx_en(en1), .tx_data(d1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] crc_ref(input logic [7:0] msg [$]);
        logic [31:0] c = 32'hFFFF_FFFF;
        foreach (msg[i]) begin
            c = c ^ {24'h0, msg[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    task automatic wr(input int a, input logic [7:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 11'(a); wr_data = d;
        mem_model[a] = d;
    endtask

    task automatic wr_stop();
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic build(input int n_req, input bit pad);
        logic [7:0] msg [$];
        logic [31:0] fcs;
        int n;
        n = (n_req > 1514) ? 1514 : n_req;
        exp_q.delete();
        repeat (7) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int k = 0; k < n; k++) msg.push_back(mem_model[k]);
        if (pad) while (msg.size() < 60) msg.push_back(8'h00);
        foreach (msg[i]) exp_q.push_back(msg[i]);
        fcs = ~crc_ref(msg);
        for (int i = 0; i < 4; i++) exp_q.push_back(fcs[8*i +: 8]);
    endtask

    // Starts a frame and records the selected instance until its done pulse.
    task automatic send(input int n, input bit sel, input int poke);
        logic e, dn;
        logic [7:0] dat;
        cap.delete();
        first_en = -1; last_en = -1; done_cyc = -1; nz = 0; busy_at1 = 0;
        @(negedge clk);
        start = 1'b1; len = 11'(n);
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i <= 2000 && done_cyc < 0; i++) begin
            if (i == poke) begin
                start = 1'b1; wr_en = 1'b1; wr_addr = '0; wr_data = 8'hFF;
            end
            @(posedge clk); #1;
            if (i == poke) begin
                start = 1'b0; wr_en = 1'b0;
            end
            e = sel ? en1 : en0;
            dat = sel ? d1 : d0;
            dn = sel ? done1 : done0;
            if (i == 1) busy_at1 = int'(sel ? busy1 : busy0);
            if (e) begin
                if (first_en < 0) first_en = i;
                last_en = i;
                cap.push_back(dat);
            end else if (dat != 8'h00) begin
                nz++;
            end
            if (dn) done_cyc = i;
        end
        chk("done_seen", 32'(done_cyc > 0), 32'd1);
    endtask

    task automatic check_frame(input string t, input bit sel);
        int m;
        chk({t, "_first_en"}, 32'(first_en), 32'd1);
        chk({t, "_busy_t1"}, 32'(busy_at1), 32'd1);
        chk({t, "_en_len"}, 32'(cap.size()), 32'(exp_q.size()));
        chk({t, "_en_contig"}, 32'(last_en - first_en + 1), 32'(exp_q.size()));
        m = (cap.size() < exp_q.size()) ? cap.size() : exp_q.size();
        for (int i = 0; i < m; i++) chk($sformatf("%s_byte%0d", t, i), 32'(cap[i]), 32'(exp_q[i]));
        chk({t, "_txd_idle_zero"}, 32'(nz), 32'd0);
        chk({t, "_done_cyc"}, 32'(done_cyc), 32'(exp_q.size() + 12));
        chk({t, "_busy_at_done"}, 32'(sel ? busy1 : busy0), 32'd0);
        @(posedge clk); #1;
        chk({t, "_done_pulse"}, 32'(sel ? done1 : done0), 32'd0);
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((busy0 || busy1) && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        chk("idle_timeout", 32'(t < 3000), 32'd1);
    endtask

    initial begin
        int stray;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_tx_en", 32'(en1), 32'd0);
        chk("rst_tx_data", 32'(d1), 32'd0);
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_done", 32'(done1), 32'd0);
        chk("rst_tx_en0", 32'(en0), 32'd0);
        reset_n = 1'b1;

        // "123456789" -> FCS 26 39 F4 CB, hand-written expectation.
        for (int i = 0; i < 9; i++) wr(i, 8'h31 + 8'(i));
        wr_stop();
        exp_q.delete();
        repeat (7) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 0; i < 9; i++) exp_q.push_back(8'h31 + 8'(i));
        exp_q.push_back(8'h26); exp_q.push_back(8'h39);
        exp_q.push_back(8'hF4); exp_q.push_back(8'hCB);
        send(9, 1'b0, 0);
        chk("crcvec_done_t33", 32'(done_cyc), 32'd33);
        check_frame("crcvec", 1'b0);
        wait_idle();

        // Padded frame with a start and a write landing mid-frame.
        for (int i = 0; i < 14; i++) wr(i, 8'hAA);
        wr_stop();
        build(14, 1'b1);
        send(14, 1'b1, 20);
        chk("pad_en_72", 32'(cap.size()), 32'd72);
        check_frame("pad", 1'b1);
        wait_idle();
        stray = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (en0 || en1 || busy0 || busy1) stray++;
        end
        chk("no_second_frame", 32'(stray), 32'd0);
        send(14, 1'b1, 0);
        check_frame("resend", 1'b1);
        chk("resend_addr0", 32'(cap[8]), 32'hAA);
        wait_idle();

        // Zero-length frames on both instances.
        build(0, 1'b1);
        send(0, 1'b1, 0);
        check_frame("len0_pad", 1'b1);
        wait_idle();
        exp_q.delete();
        repeat (7) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        repeat (4) exp_q.push_back(8'h00);
        send(0, 1'b0, 0);
        check_frame("len0_nopad", 1'b0);
        wait_idle();

        // Length clamp.
        for (int i = 0; i < 1514; i++) wr(i, 8'((i * 7 + 3) & 8'hFF));
        wr_stop();
        build(2000, 1'b1);
        send(2000, 1'b1, 0);
        chk("clamp_data_bytes", 32'(cap.size() - 12), 32'd1514);
        check_frame("clamp", 1'b1);
        wait_idle();

        // Reset asserted for the edge carrying DATA byte 20.
        @(negedge clk);
        start = 1'b1; len = 11'd30;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (28) @(posedge clk);
        #1;
        chk("mid_byte19_en", 32'(en1), 32'd1);
        chk("mid_byte19_data", 32'(d1), 32'(mem_model[19]));
        reset_n = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_en", 32'(en1), 32'd0);
        chk("mid_rst_data", 32'(d1), 32'd0);
        chk("mid_rst_busy", 32'(busy1), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        build(30, 1'b1);
        send(30, 1'b1, 0);
        check_frame("after_rst", 1'b1);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
